// File: rtl/cell_exerciser_pkg.sv
// Shared definitions for the cell exerciser: register map, MISR constants,
// FSM states and the STATUS word layout.
package cell_exerciser_pkg;

    localparam int unsigned SIG_W = 32;

    localparam logic [4:0] REG_CTRL   = 5'h00;
    localparam logic [4:0] REG_LAST   = 5'h04;
    localparam logic [4:0] REG_EXPECT = 5'h08;
    localparam logic [4:0] REG_STATUS = 5'h0C;
    localparam logic [4:0] REG_SIG    = 5'h10;

    localparam logic [SIG_W-1:0] MISR_POLY = 32'h0040_0007;
    localparam logic [SIG_W-1:0] MISR_SEED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_FINISH = 2'd3
    } state_e;

    typedef struct packed {
        logic [15:0] idx;
        logic [12:0] rsvd;
        logic        pass;
        logic        done;
        logic        busy;
    } status_t;

    // One shift of the Galois-style signature register with data folded in.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                   input logic [SIG_W-1:0] data);
        return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ data;
    endfunction

endpackage

// File: rtl/cell_exerciser_if.sv
// Wishbone classic slave bus bundle for the cell exerciser.
interface cell_exerciser_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/cell_exerciser_misr.sv
// 32-bit multiple-input signature register; seed load has priority over update.
module cell_exerciser_misr
    import cell_exerciser_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_seed,
    input  logic             i_en,
    input  logic [SIG_W-1:0] i_data,
    output logic [SIG_W-1:0] o_sig
);

    logic [SIG_W-1:0] r_sig;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sig <= '0;
        end else if (i_seed) begin
            r_sig <= MISR_SEED;
        end else if (i_en) begin
            r_sig <= misr_step(r_sig, i_data);
        end
    end

    assign o_sig = r_sig;

endmodule

// File: rtl/cell_exerciser.sv
// Wishbone-controlled stimulus sweeper with MISR response compaction.
// Optional CELL_EXERCISER_CONTINUOUS_EN adds CTRL bit2 (CONT) to loop runs.
module cell_exerciser
    import cell_exerciser_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned N_STIM    = 16,
    parameter int unsigned N_RESP    = 16,
    parameter int unsigned SETTLE    = 4
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_ni,
    cell_exerciser_if.slave   wb,
    output logic [N_STIM-1:0] stim_o,
    input  logic [N_RESP-1:0] resp_i,
    output logic              done_irq_o
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e             r_state, w_next;
    logic               r_ack, r_done, r_pass, r_irq;
    logic [31:0]        r_dat, r_expect;
    logic [N_STIM-1:0]  r_idx, r_last;
    logic [CNT_W-1:0]   r_cnt;
    logic [4:0]         w_off;
    logic [31:0]        w_rdata;
    logic [SIG_W-1:0]   w_sig;
    status_t            w_status;
    logic               w_req, w_wr, w_start, w_abort, w_busy, w_settled, w_is_last;
    logic               w_seed, w_misr_en, w_idx_inc, w_res_clr, w_finish, w_cont;
    logic               w_unused;

    // Bus decode: one request per ack, word-aligned offsets inside the window.
    assign w_off     = {wb.wbs_adr_i[4:2], 2'b00};
    assign w_req     = wb.wbs_stb_i & wb.wbs_cyc_i & ~r_ack
                       & (wb.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    assign w_wr      = w_req & wb.wbs_we_i;
    assign w_start   = w_wr & (w_off == REG_CTRL) & wb.wbs_dat_i[0] & ~wb.wbs_dat_i[1];
    assign w_abort   = w_wr & (w_off == REG_CTRL) & wb.wbs_dat_i[1];
    assign w_busy    = (r_state != ST_IDLE);
    assign w_settled = (r_cnt == CNT_W'(SETTLE - 1));
    assign w_is_last = (r_idx == r_last);
    assign w_unused  = ^{wb.wbs_sel_i, wb.wbs_adr_i[1:0]};

`ifdef CELL_EXERCISER_CONTINUOUS_EN
    logic r_cont;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cont <= 1'b0;
        end else if (w_wr && (w_off == REG_CTRL)) begin
            r_cont <= wb.wbs_dat_i[2];
        end
    end

    assign w_cont = r_cont;
`else
    assign w_cont = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_start) w_next = ST_APPLY;
            ST_APPLY:  if (w_abort) w_next = ST_IDLE;
                       else if (w_settled) w_next = ST_SAMPLE;
            ST_SAMPLE: if (w_abort) w_next = ST_IDLE;
                       else w_next = w_is_last ? ST_FINISH : ST_APPLY;
            ST_FINISH: w_next = (w_cont && !w_abort) ? ST_APPLY : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Datapath strobes; an abort suppresses every update in the same cycle.
    always_comb begin
        w_seed    = 1'b0;
        w_misr_en = 1'b0;
        w_idx_inc = 1'b0;
        w_res_clr = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_seed    = w_start;
                w_res_clr = w_start;
            end
            ST_APPLY:  w_res_clr = w_abort;
            ST_SAMPLE: begin
                w_res_clr = w_abort;
                w_misr_en = ~w_abort;
                w_idx_inc = ~w_abort & ~w_is_last;
            end
            ST_FINISH: begin
                w_res_clr = w_abort;
                w_finish  = ~w_abort;
                w_seed    = ~w_abort & w_cont;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_last   <= '0;
            r_expect <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) r_dat <= w_rdata;
            if (w_wr && (w_off == REG_LAST) && !w_busy) r_last <= wb.wbs_dat_i[N_STIM-1:0];
            if (w_wr && (w_off == REG_EXPECT)) r_expect <= wb.wbs_dat_i;
            if (w_seed) r_idx <= '0;
            else if (w_idx_inc) r_idx <= r_idx + N_STIM'(1);
            r_cnt <= (r_state == ST_APPLY && w_next == ST_APPLY) ? r_cnt + CNT_W'(1) : '0;
            if (w_res_clr) begin
                r_done <= 1'b0;
                r_pass <= 1'b0;
            end else if (w_finish) begin
                r_done <= 1'b1;
                r_pass <= (w_sig == r_expect);
            end
            r_irq <= w_finish;
        end
    end

    always_comb begin
        w_status      = '0;
        w_status.idx  = 16'(r_idx);
        w_status.pass = r_pass;
        w_status.done = r_done;
        w_status.busy = w_busy;
        w_rdata       = '0;
        case (w_off)
            REG_CTRL:   w_rdata = {29'd0, w_cont, 2'b00};
            REG_LAST:   w_rdata = 32'(r_last);
            REG_EXPECT: w_rdata = r_expect;
            REG_STATUS: w_rdata = w_status;
            REG_SIG:    w_rdata = w_sig;
            default:    w_rdata = '0;
        endcase
    end

    cell_exerciser_misr u_misr (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_seed  (w_seed),
        .i_en    (w_misr_en),
        .i_data  (32'(resp_i)),
        .o_sig   (w_sig)
    );

    assign wb.wbs_ack_o = r_ack;
    assign wb.wbs_dat_o = r_dat;
    assign stim_o       = r_idx;
    assign done_irq_o   = r_irq;

endmodule

// File: doc/cell_exerciser.md
# cell_exerciser

Self-contained on-chip tester for the standard-cell test structures. It drives a binary stimulus sweep into the cell inputs, waits a programmable settle time, and compresses the sampled cell outputs into a 32-bit MISR signature. The signature is compared against an expected value. Firmware controls the block through the Caravel Wishbone slave port, and results are read back over Wishbone, so no external pad stimulus is needed.

## Interface
- `BASE_ADDR`, 32'h3000_0000: Wishbone base; decode on `wbs_adr_i[31:5]`.
- `N_STIM`, 16: stimulus bus width; also the pattern index width.
- `N_RESP`, 16: response bus width; must be ≤ 32.
- `SETTLE`, 4: cycles each pattern is held before sampling; must be ≥ 1.
- `wb_clk_i` in 1: single clock.
- `wb_rst_ni` in 1: asynchronous, active-low reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone classic strobe, cycle and write enable.
- `wbs_sel_i` in 4: byte selects; ignored, all writes are full-word.
- `wbs_adr_i`, `wbs_dat_i` in 32: address and write data.
- `wbs_ack_o` out 1: transfer acknowledge.
- `wbs_dat_o` out 32: read data.
- `stim_o` out N_STIM: stimulus to the cell inputs.
- `resp_i` in N_RESP: cell outputs; combinational, no synchronizer.
- `done_irq_o` out 1: one-cycle pulse when a run completes.

## Operation
- Register map, word offsets:
  - 0x00 CTRL, W: bit0 START and bit1 ABORT, both write-1 self-clearing. Reads 0.
  - 0x04 LAST, RW: index of the final pattern, N_STIM bits.
  - 0x08 EXPECT, RW: expected 32-bit signature.
  - 0x0C STATUS, RO: bit0 busy, bit1 done, bit2 pass, bits[31:16] current index (zero-extended).
  - 0x10 SIG, RO: current MISR value.
  - Any other offset reads 0; writes to it are dropped.
- FSM states: IDLE, APPLY, SAMPLE, FINISH.
- IDLE: START clears done and pass, sets idx=0 and sig=32'hFFFF_FFFF, then enters APPLY.
- APPLY: `stim_o`=idx; the settle counter runs SETTLE cycles, then the FSM enters SAMPLE.
- SAMPLE: one cycle. Update sig = ({sig[30:0],1'b0} ^ (sig[31] ? 32'h0040_0007 : 0)) ^ zero-extended `resp_i`.
  - If idx==LAST, go to FINISH.
  - Otherwise idx+1 and return to APPLY.
- FINISH: one cycle. Set done, set pass=(sig==EXPECT), pulse `done_irq_o`, return to IDLE.
- `stim_o` holds its last value in IDLE.
- idx never wraps. LAST=2^N_STIM−1 sweeps the full space and terminates.
- START while busy: ignored.
- LAST write while busy: ignored.
- EXPECT write: always accepted. The compare uses the value present in FINISH.
- ABORT in any busy state: the next state is IDLE with done=0, pass=0; sig and `stim_o` are held.
- START and ABORT in the same write: ABORT wins and no run starts.
- Reset values: `stim_o`=0, LAST=0, EXPECT=0, sig=0, idx=0, busy=done=pass=0, `wbs_ack_o`=0, `wbs_dat_o`=0, `done_irq_o`=0, state IDLE.
- Reset mid-run: all state returns to reset values immediately; no partial result is retained.

## Timing
- Wishbone: `wbs_ack_o` is registered and asserts the cycle after stb&cyc&!ack. It is high for exactly one cycle.
- Wishbone read data is registered alongside ack.
- The write takes effect on the ack edge.
- START written on the ack edge → APPLY on the next cycle.
- Per pattern: SETTLE+1 cycles.
- A run takes (LAST+1)·(SETTLE+1)+1 cycles from entering APPLY to done=1.
- The sampled `resp_i` is the value present on the SAMPLE cycle.

## Configuration
- `CELL_EXERCISER_CONTINUOUS_EN`:
  - Defined: CTRL bit2 CONT (RW) exists. With CONT=1, FINISH restarts the run (idx=0, sig reseeded) instead of entering IDLE. done, pass and `done_irq_o` still update every pass. ABORT or clearing CONT stops the loop at the next FINISH.
  - Undefined: bit2 reads 0 and writes to it are ignored.

## Structure
- `cell_exerciser_pkg` holds:
  - register offsets;
  - MISR polynomial 32'h0040_0007 and seed 32'hFFFF_FFFF;
  - the FSM state enum.
- Sub-module `cell_exerciser_misr` contains the signature register with seed, enable and data inputs.
- Register decode and the FSM stay in the top module.

## Test plan
- Reset applied → all outputs 0; STATUS reads 0; SIG reads 0.
- LAST=0, `resp_i`=0, START → after SETTLE+2 cycles SIG=32'hFFBF_FFF9, done=1. With EXPECT=32'hFFBF_FFF9, pass=1; with EXPECT=0, pass=0.
- LAST=3, SETTLE=4 → `stim_o` steps 0,1,2,3 every 5 cycles; busy lasts 21 cycles; `done_irq_o` pulses exactly once.
- ABORT at idx=2 → busy=0, done=0 next cycle; a write to LAST during the run leaves LAST unchanged.
- START+ABORT in the same write from IDLE → no run. START while busy → run length unchanged.
- Assert `wb_rst_ni` mid-run at idx=5 → asynchronous clear; `stim_o`=0 with no clock edge.
